// File: rtl/shift_arbiter_ctrl.sv
// +----------------------------------------------------------------------------+
// | shift_arbiter_ctrl: round-robin arbiter/sequencer sharing one barrel shifter |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module shift_arbiter_ctrl #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] a_data,
  input  logic [AW-1:0] a_amt,
  input  logic          a_lr,
  input  logic          a_al,
  input  logic          a_step,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [DW-1:0] b_data,
  input  logic [AW-1:0] b_amt,
  input  logic          b_lr,
  input  logic          b_al,
  input  logic          b_step,
  output logic [DW-1:0] sh_din,
  output logic [AW-1:0] sh_amt,
  output logic          sh_lr,
  output logic          sh_al,
  input  logic [DW-1:0] sh_dout,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] work_q;
  logic [DW-1:0] rsp_data_q;
  logic [AW-1:0] cnt_q;
  logic          lr_q;
  logic          al_q;
  logic          step_q;
  logic          id_q;
  logic          last_grant_q;
  logic          rsp_valid_q;
  logic          busy_q;

  logic          gnt_a_d;
  logic          gnt_b_d;
  logic          accept_d;
  logic [DW-1:0] sel_data_d;
  logic [AW-1:0] sel_amt_d;
  logic          sel_lr_d;
  logic          sel_al_d;
  logic          sel_step_d;
  logic          in_idle_d;
  logic          in_shift_d;

  assign in_idle_d  = (state_q == IDLE);
  assign in_shift_d = (state_q == SHIFT);

  // last_grant_q==1 means B was served last, so A takes the next tie.
  assign gnt_a_d  = in_idle_d & a_valid & (~b_valid | last_grant_q);
  assign gnt_b_d  = in_idle_d & b_valid & (~a_valid | ~last_grant_q);
  assign accept_d = gnt_a_d | gnt_b_d;

  assign sel_data_d = gnt_b_d ? b_data : a_data;
  assign sel_amt_d  = gnt_b_d ? b_amt  : a_amt;
  assign sel_lr_d   = gnt_b_d ? b_lr   : a_lr;
  assign sel_al_d   = gnt_b_d ? b_al   : a_al;
  assign sel_step_d = gnt_b_d ? b_step : a_step;

  assign a_ready = gnt_a_d;
  assign b_ready = gnt_b_d;

  assign sh_din = in_shift_d ? work_q : '0;
  assign sh_amt = in_shift_d ? (step_q ? AW'(1) : cnt_q) : '0;
  assign sh_lr  = in_shift_d & lr_q;
  assign sh_al  = in_shift_d & al_q;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      work_q       <= '0;
      rsp_data_q   <= '0;
      cnt_q        <= '0;
      lr_q         <= 1'b0;
      al_q         <= 1'b0;
      step_q       <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_d) begin
            work_q       <= sel_data_d;
            cnt_q        <= sel_amt_d;
            lr_q         <= sel_lr_d;
            al_q         <= sel_al_d;
            step_q       <= sel_step_d;
            id_q         <= gnt_b_d;
            last_grant_q <= gnt_b_d;
            busy_q       <= 1'b1;
            if (sel_amt_d == '0) begin
              rsp_data_q  <= sel_data_d;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= sh_dout;
          if (step_q) begin
            cnt_q <= cnt_q - AW'(1);
          end
          if (!step_q || (cnt_q == AW'(1))) begin
            rsp_data_q  <= sh_dout;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end
        RESP: begin
          // Returning to IDLE rather than accepting here forces the one-cycle bubble.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_shift_arbiter_ctrl: directed bench with a behavioural barrel shifter      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_shift_arbiter_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_valid, a_ready, a_lr, a_al, a_step;
  logic [7:0] a_data;
  logic [2:0] a_amt;
  logic       b_valid, b_ready, b_lr, b_al, b_step;
  logic [7:0] b_data;
  logic [2:0] b_amt;
  logic [7:0] sh_din, sh_dout;
  logic [2:0] sh_amt;
  logic       sh_lr, sh_al;
  logic       rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    sh_dout = '0;
    if (sh_lr)      sh_dout = sh_din << sh_amt;
    else if (sh_al) sh_dout = 8'($signed(sh_din) >>> sh_amt);
    else            sh_dout = sh_din >> sh_amt;
  end

  shift_arbiter_ctrl #(.DW(8), .AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt),
    .a_lr(a_lr), .a_al(a_al), .a_step(a_step),
    .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt),
    .b_lr(b_lr), .b_al(b_al), .b_step(b_step),
    .sh_din(sh_din), .sh_amt(sh_amt), .sh_lr(sh_lr), .sh_al(sh_al), .sh_dout(sh_dout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [7:0] d, input logic [2:0] amt,
                         input logic lr, input logic al, input logic st);
    a_data = d; a_amt = amt; a_lr = lr; a_al = al; a_step = st; a_valid = 1'b1;
  endtask

  task automatic drive_b(input logic [7:0] d, input logic [2:0] amt,
                         input logic lr, input logic al, input logic st);
    b_data = d; b_amt = amt; b_lr = lr; b_al = al; b_step = st; b_valid = 1'b1;
  endtask

  // Waits (bounded) for the chosen ready, takes the accept edge, drops valid.
  task automatic accept(input logic is_b, input string tag);
    int n = 0;
    #1;
    while (!(is_b ? b_ready : a_ready) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rdy"}, {31'd0, (is_b ? b_ready : a_ready)}, 32'd1);
    tick();
    if (is_b) b_valid = 1'b0;
    else      a_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int lat, input logic id, input logic [7:0] data);
    int n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, lat);
    check({tag, "_id"}, {31'd0, rsp_id}, {31'd0, id});
    check({tag, "_data"}, {24'd0, rsp_data}, {24'd0, data});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_idle"}, {30'd0, busy, rsp_valid}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n) check("ready_excl", {31'd0, a_ready & b_ready}, 32'd0);
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    a_valid = 1'b0; a_data = '0; a_amt = '0; a_lr = 1'b0; a_al = 1'b0; a_step = 1'b0;
    b_valid = 1'b0; b_data = '0; b_amt = '0; b_lr = 1'b0; b_al = 1'b0; b_step = 1'b0;
    #12;
    check("rst_ctrl", {26'd0, a_ready, b_ready, rsp_valid, busy, sh_lr, sh_al}, 32'd0);
    check("rst_sh", {21'd0, sh_din, sh_amt}, 32'd0);
    check("rst_rsp", {23'd0, rsp_id, rsp_data}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // A: single left logical shift by 3
    drive_a(8'b1001_0110, 3'd3, 1'b1, 1'b0, 1'b0);
    accept(1'b0, "a_sl3");
    check("a_sl3_busy", {31'd0, busy}, 32'd1);
    check("a_sl3_sh", {20'd0, sh_din, sh_amt, sh_lr}, {20'd0, 8'h96, 3'd3, 1'b1});
    wait_rsp("a_sl3", 1, 1'b0, 8'hB0);

    // B: right arithmetic then right logical by 2
    drive_b(8'h96, 3'd2, 1'b0, 1'b1, 1'b0);
    accept(1'b1, "b_sra");
    wait_rsp("b_sra", 1, 1'b1, 8'hE5);
    drive_b(8'h96, 3'd2, 1'b0, 1'b0, 1'b0);
    accept(1'b1, "b_srl");
    wait_rsp("b_srl", 1, 1'b1, 8'h25);

    // A stepped: walking bit, one 1-bit pass per cycle
    drive_a(8'h01, 3'd4, 1'b1, 1'b0, 1'b1);
    accept(1'b0, "stp");
    for (int i = 0; i < 4; i++) begin
      check("stp_amt", {29'd0, sh_amt}, 32'd1);
      check("stp_din", {24'd0, sh_din}, 32'h1 << i);
      check("stp_novalid", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    wait_rsp("stp", 0, 1'b0, 8'h10);

    // Tie from reset: A first, B after response plus bubble
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    drive_a(8'h0F, 3'd1, 1'b1, 1'b0, 1'b0);
    drive_b(8'hF0, 3'd1, 1'b0, 1'b1, 1'b0);
    #1;
    check("tie_first", {30'd0, a_ready, b_ready}, 32'b10);
    tick();
    a_valid = 1'b0;
    check("tie_shift_brdy", {31'd0, b_ready}, 32'd0);
    tick();
    check("tie_resp_brdy", {30'd0, rsp_valid, b_ready}, 32'b10);
    check("tie_a_data", {23'd0, rsp_id, rsp_data}, {23'd0, 1'b0, 8'h1E});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("tie_bubble_brdy", {31'd0, b_ready}, 32'd1);
    accept(1'b1, "tie_b");
    wait_rsp("tie_b", 1, 1'b1, 8'hF8);

    // A alone, then tie: B wins, then A
    drive_a(8'h03, 3'd2, 1'b1, 1'b0, 1'b0);
    accept(1'b0, "solo_a");
    wait_rsp("solo_a", 1, 1'b0, 8'h0C);
    drive_a(8'h80, 3'd7, 1'b0, 1'b1, 1'b0);
    drive_b(8'hC3, 3'd4, 1'b1, 1'b0, 1'b0);
    #1;
    check("tie2_first", {30'd0, a_ready, b_ready}, 32'b01);
    accept(1'b1, "tie2_b");
    wait_rsp("tie2_b", 1, 1'b1, 8'h30);
    accept(1'b0, "tie2_a");
    wait_rsp("tie2_a", 1, 1'b0, 8'hFF);

    // amt==0 bypass and response back-pressure
    drive_a(8'h5A, 3'd0, 1'b1, 1'b0, 1'b0);
    accept(1'b0, "zero");
    check("zero_valid", {31'd0, rsp_valid}, 32'd1);
    check("zero_sh", {21'd0, sh_din, sh_amt}, 32'd0);
    drive_a(8'hA5, 3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("hold_ardy", {31'd0, a_ready}, 32'd0);
      check("hold_rsp", {22'd0, rsp_valid, rsp_id, rsp_data}, {22'd0, 1'b1, 1'b0, 8'h5A});
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    accept(1'b0, "after_hold");
    wait_rsp("after_hold", 1, 1'b0, 8'h52);

    // Reset during stepped shift drops the command
    drive_a(8'h01, 3'd7, 1'b1, 1'b0, 1'b1);
    accept(1'b0, "abort");
    tick();
    tick();
    check("abort_din", {24'd0, sh_din}, 32'h04);
    rst_n = 1'b0;
    #1;
    check("abort_state", {28'd0, busy, rsp_valid, a_ready, b_ready}, 32'd0);
    check("abort_sh", {21'd0, sh_din, sh_amt}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("abort_norsp", {30'd0, rsp_valid, busy}, 32'd0);
      tick();
    end
    drive_a(8'h81, 3'd1, 1'b0, 1'b1, 1'b0);
    accept(1'b0, "post_abort");
    wait_rsp("post_abort", 1, 1'b0, 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
